// File: rtl/qr_result_serializer.sv
// Buffers per-RE QR results ({R, y_hat}) and streams them out as OUT_W-bit
// valid/ready beats, marking the final beat of each tagged group-final result.
module qr_result_serializer #(
    parameter int OUT_W = 40,
    parameter int DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_rd_vld,
    input  logic                     i_last_data,
    input  logic [159:0]             i_y_hat,
    input  logic [319:0]             i_r,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [OUT_W-1:0]         o_data,
    output logic                     o_first,
    output logic                     o_last,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow
);

    localparam int WORD_W = 480;
    localparam int BEATS  = WORD_W / OUT_W;
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;
    localparam int BW     = $clog2(BEATS);

    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [BW-1:0] LAST_B = BW'(BEATS - 1);

    typedef enum logic {
        S_EMPTY,
        S_SEND
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_tag;
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [BW-1:0]     r_b;
    logic              r_wrote_prev;
    logic [PW-1:0]     r_prev_idx;
    logic              r_overflow;

    logic              w_xfer;
    logic              w_pop;
    logic              w_full;
    logic              w_push;
    logic              w_drop;
    logic              w_late_tag;
    logic [CW-1:0]     w_count_nxt;
    logic [OUT_W-1:0]  w_beat;

    assign w_xfer      = o_valid & i_ready;
    assign w_pop       = w_xfer & (r_b == LAST_B);
    assign w_full      = (r_count == FULL);
    // A full buffer still accepts when the head pops on the same edge
    assign w_push      = i_rd_vld & (~w_full | w_pop);
    assign w_drop      = i_rd_vld & w_full & ~w_pop;
    assign w_late_tag  = i_last_data & ~i_rd_vld & r_wrote_prev;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign w_beat      = r_mem[r_rptr][r_b*OUT_W +: OUT_W];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {i_r, i_y_hat};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_b          <= '0;
            r_tag        <= '0;
            r_wrote_prev <= 1'b0;
            r_prev_idx   <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_count      <= w_count_nxt;
            r_wrote_prev <= w_push;
            if (w_push) begin
                r_wptr        <= r_wptr + PW'(1);
                r_prev_idx    <= r_wptr;
                r_tag[r_wptr] <= i_last_data;
            end
            // Late mark may hit an entry that is already being serialized
            if (w_late_tag) begin
                r_tag[r_prev_idx] <= 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
                r_b    <= '0;
            end else if (w_xfer) begin
                r_b <= r_b + BW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_EMPTY: if (w_count_nxt != '0) w_state_nxt = S_SEND;
            S_SEND:  if (w_count_nxt == '0) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        o_valid = 1'b0;
        o_data  = '0;
        o_first = 1'b0;
        o_last  = 1'b0;
        if (r_state == S_SEND) begin
            o_valid = 1'b1;
            o_data  = w_beat;
            o_first = (r_b == '0);
            o_last  = (r_b == LAST_B) & r_tag[r_rptr];
        end
    end

    assign o_level    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_qr_result_serializer.sv
// Directed bench for qr_result_serializer: queue-based result model checked
// every cycle, plus literal expectations on beat order, tags and overflow.
module tb_qr_result_serializer;

    localparam int OUT_W = 40;
    localparam int DEPTH = 2;
    localparam int BEATS = 12;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rd_vld = 1'b0;
    logic         last_data = 1'b0;
    logic         ready = 1'b0;
    logic [159:0] y = '0;
    logic [319:0] r = '0;
    logic         o_valid;
    logic [39:0]  o_data;
    logic         o_first;
    logic         o_last;
    logic [1:0]   o_level;
    logic         o_overflow;

    int checks = 0;
    int errors = 0;

    qr_result_serializer #(.OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rd_vld    (rd_vld),
        .i_last_data (last_data),
        .i_y_hat     (y),
        .i_r         (r),
        .o_valid     (o_valid),
        .i_ready     (ready),
        .o_data      (o_data),
        .o_first     (o_first),
        .o_last      (o_last),
        .o_level     (o_level),
        .o_overflow  (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] lane(logic [7:0] b, int k);
        return {b, 32'(k)};
    endfunction

    function automatic logic [159:0] mk_y(logic [7:0] b);
        logic [159:0] v;
        for (int k = 0; k < 4; k++) v[k*40 +: 40] = lane(b, k);
        return v;
    endfunction

    function automatic logic [319:0] mk_r(logic [7:0] b);
        logic [319:0] v;
        for (int k = 0; k < 8; k++) v[k*40 +: 40] = lane(b, k);
        return v;
    endfunction

    // Result model: list of buffered results, beat index of the head
    typedef struct {
        logic [479:0] data;
        bit           tag;
        int           id;
    } ent_t;

    ent_t mq[$];
    int   mb = 0;
    bit   movf = 0;
    int   next_id = 0;
    bit   prev_ok = 0;
    int   prev_id = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mb = 0;
            movf = 0;
            prev_ok = 0;
        end else begin
            bit   xfer;
            bit   pop;
            bit   acc;
            ent_t e;
            xfer = (mq.size() > 0) && ready;
            pop = xfer && (mb == BEATS - 1);
            if (last_data && !rd_vld && prev_ok)
                foreach (mq[i]) if (mq[i].id == prev_id) mq[i].tag = 1;
            if (pop) void'(mq.pop_front());
            acc = rd_vld && (mq.size() < DEPTH);
            if (rd_vld && !acc) movf = 1;
            if (acc) begin
                e.data = {r, y};
                e.tag = last_data;
                e.id = next_id;
                mq.push_back(e);
                prev_id = next_id;
                next_id++;
            end
            prev_ok = acc;
            if (xfer) mb = pop ? 0 : mb + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            bit          ev;
            logic [39:0] ed;
            bit          el;
            ev = mq.size() > 0;
            ed = '0;
            el = 0;
            if (ev) begin
                ed = 40'(mq[0].data >> (mb * OUT_W));
                el = mq[0].tag && (mb == BEATS - 1);
            end
            chk("m_valid", o_valid, ev);
            chk("m_data", o_data, ed);
            chk("m_first", o_first, ev && mb == 0);
            chk("m_last", o_last, el);
            chk("m_level", o_level, mq.size());
            chk("m_ovf", o_overflow, movf);
        end
    end

    logic [39:0] cap[$];
    int nfirst = 0;
    int nlast = 0;
    int last_at = -1;

    always @(negedge clk) begin
        if (!rst && o_valid && ready) begin
            cap.push_back(o_data);
            if (o_first) nfirst++;
            if (o_last) begin
                nlast++;
                last_at = cap.size() - 1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(logic [7:0] b, bit ld);
        y = mk_y(b);
        r = mk_r(b + 8'h10);
        rd_vld = 1'b1;
        last_data = ld;
        cyc();
        rd_vld = 1'b0;
        last_data = 1'b0;
    endtask

    task automatic clear_cap();
        cap.delete();
        nfirst = 0;
        nlast = 0;
        last_at = -1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic run_group(bit coincident);
        clear_cap();
        for (int g = 0; g < 10; g++) begin
            y = mk_y(8'(g));
            r = mk_r(8'(g + 8'h40));
            rd_vld = 1'b1;
            last_data = coincident && (g == 9);
            cyc();
            rd_vld = 1'b0;
            last_data = 1'b0;
            if (g == 9 && !coincident) begin
                last_data = 1'b1;
                cyc();
                last_data = 1'b0;
                repeat (18) cyc();
            end else begin
                repeat (19) cyc();
            end
        end
        chk("grp_beats", cap.size(), 120);
        chk("grp_nlast", nlast, 1);
        chk("grp_last_at", last_at, 119);
    endtask

    initial begin
        repeat (3) cyc();
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_level", o_level, 0);
        chk("rst_ovf", o_overflow, 0);
        rst = 1'b0;
        cyc();

        // single result
        ready = 1'b1;
        clear_cap();
        strobe(8'h10, 1'b0);
        chk("lat_valid", o_valid, 1);
        chk("lat_first", o_first, 1);
        chk("lat_beat0", o_data, 40'h10_0000_0000);
        repeat (13) cyc();
        chk("t1_count", cap.size(), 12);
        chk("t1_b3", cap[3], 40'h10_0000_0003);
        chk("t1_b4", cap[4], 40'h20_0000_0000);
        chk("t1_b11", cap[11], 40'h20_0000_0007);
        for (int k = 0; k < 12; k++)
            chk("t1_beat", cap[k], k < 4 ? lane(8'h10, k) : lane(8'h20, k - 4));
        chk("t1_first", nfirst, 1);
        chk("t1_last", nlast, 0);
        chk("t1_idle", o_valid, 0);

        // backpressure 1,0,0,1,...
        clear_cap();
        y = mk_y(8'h30);
        r = mk_r(8'h40);
        for (int i = 0; i < 60; i++) begin
            ready = (i % 4 == 0) || (i % 4 == 3);
            rd_vld = (i == 0);
            cyc();
        end
        rd_vld = 1'b0;
        ready = 1'b1;
        chk("bp_count", cap.size(), 12);
        for (int k = 0; k < 12; k++)
            chk("bp_beat", cap[k], k < 4 ? lane(8'h30, k) : lane(8'h40, k - 4));

        run_group(1'b0);
        run_group(1'b1);

        // overflow
        pulse_rst();
        ready = 1'b0;
        strobe(8'h51, 1'b0);
        strobe(8'h52, 1'b0);
        strobe(8'h53, 1'b0);
        chk("ovf_level", o_level, 2);
        chk("ovf_flag", o_overflow, 1);
        clear_cap();
        ready = 1'b1;
        repeat (30) cyc();
        chk("ovf_beats", cap.size(), 24);
        chk("ovf_r1", cap[0], lane(8'h51, 0));
        chk("ovf_r2", cap[12], lane(8'h52, 0));
        chk("ovf_r2end", cap[23], lane(8'h62, 7));
        chk("ovf_sticky", o_overflow, 1);

        // full push with simultaneous pop
        pulse_rst();
        ready = 1'b0;
        strobe(8'h71, 1'b0);
        strobe(8'h72, 1'b0);
        chk("fp_full", o_level, 2);
        clear_cap();
        ready = 1'b1;
        repeat (11) cyc();
        strobe(8'h73, 1'b0);
        chk("fp_level", o_level, 2);
        chk("fp_ovf", o_overflow, 0);
        repeat (30) cyc();
        chk("fp_beats", cap.size(), 36);
        chk("fp_r3", cap[24], lane(8'h73, 0));

        // reset at beat 5
        pulse_rst();
        ready = 1'b1;
        strobe(8'h81, 1'b0);
        repeat (5) cyc();
        chk("mid_b5", o_data, lane(8'h91, 1));
        rst = 1'b1;
        cyc();
        chk("mid_valid", o_valid, 0);
        chk("mid_data", o_data, 0);
        chk("mid_first", o_first, 0);
        chk("mid_level", o_level, 0);
        rst = 1'b0;
        cyc();
        clear_cap();
        strobe(8'hA1, 1'b0);
        chk("mid_new_first", o_first, 1);
        chk("mid_new_data", o_data, lane(8'hA1, 0));
        repeat (14) cyc();
        chk("mid_new_beats", cap.size(), 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
